// File: rtl/priority_encoder_16to4.sv
// Serialising 16-to-4 priority encoder: accepts a request vector and emits
// the index of each set bit once, in priority order, under ready/valid flow control.
module priority_encoder_16to4 #(
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   input  logic [15:0] in,
   output logic        in_ready,
   output logic [3:0]  out,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        last,
   output logic        empty
);

   localparam int unsigned VEC_W = 16;
   localparam int unsigned IDX_W = 4;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   state_t             state, state_nxt;
   logic [VEC_W-1:0]   pend, pend_nxt;
   logic               empty_nxt;
   logic [IDX_W-1:0]   idx_nxt;
   logic               one_nxt;

   // State and pending-vector update from both handshakes
   always_comb begin
      state_nxt = state;
      pend_nxt  = pend;
      empty_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               if (in == '0) begin
                  empty_nxt = 1'b1;
               end else begin
                  pend_nxt  = in;
                  state_nxt = EMIT;
               end
            end
         end
         EMIT: begin
            if (out_ready) begin
               pend_nxt[out] = 1'b0;
               if (last) begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Priority pick and single-bit detect on the next pending vector
   always_comb begin
      idx_nxt = '0;
      if (MSB_FIRST) begin
         for (int i = 0; i < VEC_W; i++) begin
            if (pend_nxt[i]) idx_nxt = IDX_W'(i);
         end
      end else begin
         for (int i = VEC_W - 1; i >= 0; i--) begin
            if (pend_nxt[i]) idx_nxt = IDX_W'(i);
         end
      end
      one_nxt = (pend_nxt != '0) && ((pend_nxt & (pend_nxt - VEC_W'(1))) == '0);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         pend      <= '0;
         in_ready  <= 1'b1;
         out       <= '0;
         out_valid <= 1'b0;
         last      <= 1'b0;
         empty     <= 1'b0;
      end else begin
         state     <= state_nxt;
         pend      <= pend_nxt;
         in_ready  <= (state_nxt == IDLE);
         out       <= (state_nxt == EMIT) ? idx_nxt : '0;
         out_valid <= (state_nxt == EMIT);
         last      <= (state_nxt == EMIT) && one_nxt;
         empty     <= empty_nxt;
      end
   end

endmodule

// File: tb/tb_priority_encoder_16to4.sv
// Directed bench for priority_encoder_16to4; runs LSB-first and MSB-first
// instances side by side on the same stimulus.
module tb_priority_encoder_16to4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic [15:0] in;
   logic        out_ready;
   logic        in_ready0, out_valid0, last0, empty0;
   logic        in_ready1, out_valid1, last1, empty1;
   logic [3:0]  out0, out1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   priority_encoder_16to4 #(.MSB_FIRST(1'b0)) dut0 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in(in),
      .in_ready(in_ready0), .out(out0), .out_valid(out_valid0),
      .out_ready(out_ready), .last(last0), .empty(empty0)
   );

   priority_encoder_16to4 #(.MSB_FIRST(1'b1)) dut1 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in(in),
      .in_ready(in_ready1), .out(out1), .out_valid(out_valid1),
      .out_ready(out_ready), .last(last1), .empty(empty1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Both instances presenting an index; lsb/msb give expected out and last
   task automatic chk_emit(input string tag, input logic [3:0] e0, input logic l0,
                           input logic [3:0] e1, input logic l1);
      chk({tag, " ov0"}, 32'(out_valid0), 32'd1);
      chk({tag, " out0"}, 32'(out0), 32'(e0));
      chk({tag, " last0"}, 32'(last0), 32'(l0));
      chk({tag, " in_ready0"}, 32'(in_ready0), 32'd0);
      chk({tag, " ov1"}, 32'(out_valid1), 32'd1);
      chk({tag, " out1"}, 32'(out1), 32'(e1));
      chk({tag, " last1"}, 32'(last1), 32'(l1));
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " ov0"}, 32'(out_valid0), 32'd0);
      chk({tag, " out0"}, 32'(out0), 32'd0);
      chk({tag, " last0"}, 32'(last0), 32'd0);
      chk({tag, " in_ready0"}, 32'(in_ready0), 32'd1);
      chk({tag, " ov1"}, 32'(out_valid1), 32'd0);
      chk({tag, " in_ready1"}, 32'(in_ready1), 32'd1);
   endtask

   logic [3:0] seq0 [4];
   logic [3:0] seq1 [4];

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in        = '0;
      out_ready = 1'b1;
      #23;
      chk_idle("reset");
      chk("reset empty0", 32'(empty0), 32'd0);
      reset_n = 1'b1;
      tick();

      // 8421, full rate: LSB 0,5,10,15 / MSB 15,10,5,0
      seq0 = '{4'd0, 4'd5, 4'd10, 4'd15};
      seq1 = '{4'd15, 4'd10, 4'd5, 4'd0};
      in_valid = 1'b1;
      in       = 16'h8421;
      tick();
      in_valid = 1'b0;
      in       = '0;
      for (int k = 0; k < 4; k++) begin
         chk_emit($sformatf("v8421[%0d]", k), seq0[k], k == 3, seq1[k], k == 3);
         tick();
      end
      chk_idle("v8421 done");

      // 0030 with three stalled cycles
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in        = 16'h0030;
      tick();
      in_valid = 1'b0;
      in       = '0;
      for (int k = 0; k < 3; k++) begin
         chk_emit($sformatf("stall[%0d]", k), 4'd4, 1'b0, 4'd5, 1'b0);
         tick();
      end
      chk_emit("stall end", 4'd4, 1'b0, 4'd5, 1'b0);
      out_ready = 1'b1;
      tick();
      chk_emit("stall next", 4'd5, 1'b1, 4'd4, 1'b1);
      tick();
      chk_idle("stall done");

      // All-zero vector: one-cycle EMPTY pulse only
      in_valid = 1'b1;
      in       = 16'h0000;
      tick();
      in_valid = 1'b0;
      chk("zero empty0", 32'(empty0), 32'd1);
      chk("zero empty1", 32'(empty1), 32'd1);
      chk_idle("zero");
      tick();
      chk("zero empty0 clr", 32'(empty0), 32'd0);
      chk_idle("zero after");

      // FFFF interrupted by reset after the third output handshake
      in_valid = 1'b1;
      in       = 16'hFFFF;
      tick();
      in_valid = 1'b0;
      in       = '0;
      for (int k = 0; k < 3; k++) begin
         chk_emit($sformatf("ffff[%0d]", k), 4'(k), 1'b0, 4'(15 - k), 1'b0);
         tick();
      end
      chk_emit("ffff[3]", 4'd3, 1'b0, 4'd12, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      chk_idle("rst async");
      in_valid = 1'b1;
      in       = 16'h0001;
      tick();
      chk_idle("rst held");
      in_valid = 1'b0;
      in       = '0;
      #3;
      reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk_idle($sformatf("post rst[%0d]", k));
      end

      // 0003 then 0002 offered during EMIT; captured only after the IDLE cycle
      in_valid = 1'b1;
      in       = 16'h0003;
      tick();
      in = 16'h0002;
      chk_emit("pair a0", 4'd0, 1'b0, 4'd1, 1'b0);
      tick();
      chk_emit("pair a1", 4'd1, 1'b1, 4'd0, 1'b1);
      tick();
      chk_idle("pair gap");
      tick();
      in_valid = 1'b0;
      in       = '0;
      chk_emit("pair b", 4'd1, 1'b1, 4'd1, 1'b1);
      tick();
      chk_idle("pair done");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/priority_encoder_16to4.md
PRIORITY_ENCODER_16TO4 -- requirements
Module: priority_encoder_16to4

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 0, selecting service order: 0 = lowest set bit first, 1 = highest set bit first.
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RESET_N  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port IN_VALID  input  1  request vector on IN is offered.
REQ-005 SHALL have port IN  input  16  request vector; bit k set = request for index k.
REQ-006 SHALL have port IN_READY  output  1  block can accept a vector this cycle.
REQ-007 SHALL have port OUT  output  4  encoded index of the request currently presented.
REQ-008 SHALL have port OUT_VALID  output  1  OUT holds a valid index.
REQ-009 SHALL have port OUT_READY  input  1  consumer accepts OUT this cycle.
REQ-010 SHALL have port LAST  output  1  the presented index is the final pending request of the vector.
REQ-011 SHALL have port EMPTY  output  1  one-cycle pulse: an all-zero vector was accepted.

Function
REQ-012 SHALL implement a two-state FSM: IDLE and EMIT.
REQ-013 SHALL hold a 16-bit pending register PEND; OUT, OUT_VALID and LAST derive only from PEND and state, never from IN.
REQ-014 SHALL drive IN_READY = 1 in IDLE and 0 in EMIT.
REQ-015 SHALL accept a vector when IN_VALID and IN_READY are both 1 at a rising edge (input handshake).
REQ-016 SHALL, on an accepted nonzero vector: load PEND <= IN and enter EMIT; OUT_VALID rises in the cycle after acceptance (latency 1 cycle).
REQ-017 SHALL, on an accepted all-zero vector: stay in IDLE, leave PEND = 0, and assert EMPTY for exactly the next cycle.
REQ-018 SHALL, in EMIT, drive OUT_VALID = 1 and OUT = index of the lowest set PEND bit (MSB_FIRST=0) or highest set PEND bit (MSB_FIRST=1).
REQ-019 SHALL drive LAST = 1 in EMIT iff exactly one PEND bit is set.
REQ-020 SHALL, on output handshake (OUT_VALID and OUT_READY at an edge), clear the PEND bit at index OUT.
REQ-021 SHALL return to IDLE on the output handshake where LAST = 1; otherwise remain in EMIT.
REQ-022 SHALL keep OUT, LAST and PEND unchanged while OUT_VALID = 1 and OUT_READY = 0 (stall).
REQ-023 SHALL drive OUT = 4'h0, OUT_VALID = 0 and LAST = 0 in IDLE.
REQ-024 SHALL ignore IN and IN_VALID while in EMIT; a vector offered then is not captured and the producer must hold it.
REQ-025 SHALL insert exactly one IDLE cycle between the final output handshake of one vector and acceptance of the next (maximum rate: one index per cycle within a vector).
REQ-026 SHALL emit each set bit of an accepted vector exactly once, in strict priority order, with no duplicated or skipped index, including IN = 16'hFFFF (16 outputs) and single-bit vectors.

Reset
REQ-027 SHALL, while RESET_N = 0, immediately force state IDLE, PEND = 16'h0000, OUT = 4'h0, OUT_VALID = 0, LAST = 0 and EMPTY = 0, independent of CLK.
REQ-028 SHALL, on reset asserted mid-vector, discard all remaining pending requests; after release the block is in IDLE with IN_READY = 1.
REQ-029 SHALL accept no vector on any edge where RESET_N = 0.

Verification
REQ-030 SHALL cover: MSB_FIRST=0, IN=16'h8421 accepted, OUT_READY=1 -> OUT=0,5,10,15 on four consecutive cycles, LAST=1 only with 15, then IDLE.
REQ-031 SHALL cover: MSB_FIRST=1, IN=16'h8421 -> OUT=15,10,5,0 in that order, LAST=1 only with 0.
REQ-032 SHALL cover: IN=16'h0030, OUT_READY=0 for 3 cycles then 1 -> OUT=4 held stable for all stalled cycles, then OUT=5 with LAST=1.
REQ-033 SHALL cover: IN_VALID=1 with IN=16'h0000 in IDLE -> EMPTY=1 for one cycle, OUT_VALID stays 0, IN_READY stays 1.
REQ-034 SHALL cover: IN=16'hFFFF, RESET_N pulsed low after third output handshake -> outputs go to reset values immediately; after release IN_READY=1, no further OUT_VALID until a new vector.
REQ-035 SHALL cover: second vector 16'h0002 offered while in EMIT -> not captured until the IDLE cycle after LAST handshake, then OUT=1 with LAST=1.
